// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA display-path types, timing constants and pixel packing
package vga_pkg;

  localparam int HFP    = 16;
  localparam int HPULSE = 96;
  localparam int HBP    = 48;
  localparam int VFP    = 10;
  localparam int VPULSE = 2;
  localparam int VBP    = 33;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    REQ,
    DATA,
    DONE
  } fetch_state_t;

  function automatic logic [31:0] rgb_pack(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {8'h00, r, g, b};
  endfunction

endpackage

// File: rtl/vga_fetch_ctrl_if.sv
// rtl/vga_fetch_ctrl_if.sv - Avalon-MM read master and pixel FIFO write port bundle
interface vga_fetch_ctrl_if #(
  parameter int AW = 32,
  parameter int BW = 5,
  parameter int LW = 9
);
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic [BW-1:0] avm_burstcount;
  logic          avm_waitrequest;
  logic [31:0]   avm_readdata;
  logic          avm_readdatavalid;
  logic [LW-1:0] fifo_level;
  logic          fifo_wr;
  logic [31:0]   fifo_wdata;
  logic          fifo_clr;

  modport master (
    output avm_address, avm_read, avm_burstcount,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  fifo_level,
    output fifo_wr, fifo_wdata, fifo_clr
  );

  modport slave (
    input  avm_address, avm_read, avm_burstcount,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    output fifo_level,
    input  fifo_wr, fifo_wdata, fifo_clr
  );
endinterface

// File: rtl/vga_fetch_ctrl.sv
// rtl/vga_fetch_ctrl.sv - per-frame framebuffer burst-read scheduler feeding the pixel FIFO
module vga_fetch_ctrl
  import vga_pkg::*;
#(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int BURST      = 16,
  parameter int FIFO_DEPTH = 256,
  parameter int AW         = 32
) (
  input  logic             pixel_clk,
  input  logic             pixel_rst_n,
  input  logic             enable,
  input  logic             sof,
  input  logic [AW-1:0]    fb_base,
  vga_fetch_ctrl_if.master bus,
  output logic             busy,
  output logic             underrun
);

  localparam int TOTAL = HDISP * VDISP;
  localparam int LFW   = $clog2(TOTAL + 1);
  localparam int BW    = $clog2(BURST) + 1;
  localparam int CW    = (LFW > BW) ? LFW : BW;
  localparam logic [LFW-1:0] TOTAL_L = LFW'(TOTAL);
  localparam logic [CW-1:0]  BURST_C = CW'(BURST);

  fetch_state_t   state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [AW-1:0]  base_q, base_d;
  logic [LFW-1:0] left_q, left_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic           restart_q, restart_d;
  logic           restart_en_q, restart_en_d;
  logic           underrun_q, underrun_d;
  logic           fifo_clr_q, fifo_clr_d;

  logic [CW-1:0]  left_c;
  logic [BW-1:0]  len;
  logic           has_space;
  logic           last_beat;
  logic           fifo_wr;

  always_comb begin
    left_c    = CW'(left_q);
    len       = (left_c >= BURST_C) ? BW'(BURST_C) : BW'(left_c);
    has_space = (32'(bus.fifo_level) + 32'(len)) <= 32'(FIFO_DEPTH);
    last_beat = bus.avm_readdatavalid && (beat_q == len - BW'(1));
    // beats of a burst abandoned by a late sof are swallowed, not pushed
    fifo_wr   = (state_q == DATA) && bus.avm_readdatavalid && !restart_q;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    base_d       = base_q;
    left_d       = left_q;
    beat_d       = beat_q;
    restart_d    = restart_q;
    restart_en_d = restart_en_q;
    underrun_d   = underrun_q;
    fifo_clr_d   = 1'b0;

    if (sof) begin
      fifo_clr_d = 1'b1;
      base_d     = fb_base;
    end

    case (state_q)
      IDLE, DONE: begin
        if (sof && enable) begin
          addr_d  = fb_base;
          left_d  = TOTAL_L;
          state_d = WAIT_SPACE;
        end
      end

      WAIT_SPACE: begin
        if (sof) begin
          underrun_d = 1'b1;
          if (enable) begin
            addr_d = fb_base;
            left_d = TOTAL_L;
          end else begin
            state_d = IDLE;
          end
        end else if (has_space) begin
          state_d = REQ;
        end
      end

      REQ: begin
        if (sof) begin
          underrun_d   = 1'b1;
          restart_d    = 1'b1;
          restart_en_d = enable;
        end
        if (!bus.avm_waitrequest) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end

      DATA: begin
        if (sof) begin
          underrun_d   = 1'b1;
          restart_d    = 1'b1;
          restart_en_d = enable;
        end
        if (bus.avm_readdatavalid) begin
          beat_d = beat_q + BW'(1);
        end
        if (last_beat) begin
          if (restart_d) begin
            // restart_en_d/base_d already reflect a sof landing on this very beat
            restart_d = 1'b0;
            if (restart_en_d) begin
              addr_d  = base_d;
              left_d  = TOTAL_L;
              state_d = WAIT_SPACE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            addr_d  = addr_q + AW'({len, 2'b00});
            left_d  = left_q - LFW'(len);
            state_d = (left_q == LFW'(len)) ? DONE : WAIT_SPACE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      base_q       <= '0;
      left_q       <= '0;
      beat_q       <= '0;
      restart_q    <= 1'b0;
      restart_en_q <= 1'b0;
      underrun_q   <= 1'b0;
      fifo_clr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      base_q       <= base_d;
      left_q       <= left_d;
      beat_q       <= beat_d;
      restart_q    <= restart_d;
      restart_en_q <= restart_en_d;
      underrun_q   <= underrun_d;
      fifo_clr_q   <= fifo_clr_d;
    end
  end

  assign bus.avm_read       = (state_q == REQ);
  assign bus.avm_address    = addr_q;
  assign bus.avm_burstcount = (state_q == REQ) ? len : '0;
  assign bus.fifo_wr        = fifo_wr;
  assign bus.fifo_wdata     = fifo_wr ? bus.avm_readdata : 32'h0;
  assign bus.fifo_clr       = fifo_clr_q;

  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign underrun = underrun_q;

endmodule
